// File: rtl/midi_tx_gen.sv
// MIDI serial transmitter: pops bytes from a FIFO and sends 8N1/8N2 frames on midi_tx.
// Optional running-status suppression is enabled with `define MIDI_TX_RUNNING_STATUS_EN.
module midi_tx_gen #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int GAP_BITS     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty_n,
  output logic       fifo_rd,
  output logic       midi_tx,
  output logic       busy,
  output logic       frame_done
);
  localparam int CW = $clog2(CLKS_PER_BIT * 2);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    S_LAST = 3'(STOP_BITS - 1);
  localparam logic [3:0]    G_LAST = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bcnt;
  logic [3:0]    gcnt;
  logic [7:0]    sr;
  logic          bit_end;
  logic          suppress;

  assign bit_end = (cnt == C_LAST);
  // Pop strobe is decoded from IDLE so the byte is on fifo_data during FETCH.
  assign fifo_rd = !rst && (state == IDLE) && tx_en && fifo_empty_n;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_status;
  assign suppress = fifo_data[7] && (fifo_data[7:4] != 4'hF) && (fifo_data == last_status);

  always_ff @(posedge clk) begin
    if (rst) last_status <= 8'h00;
    else if (state == FETCH) begin
      if (fifo_data[7] && fifo_data[7:4] != 4'hF) last_status <= fifo_data;
      else if (fifo_data[7:3] == 5'b11110)        last_status <= 8'h00;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
      sr         <= 8'hFF;
      midi_tx    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (fifo_rd) begin
          state <= FETCH;
          busy  <= 1'b1;
        end
        FETCH: if (suppress) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          sr      <= fifo_data;
          midi_tx <= 1'b0;
          cnt     <= '0;
          state   <= START;
        end
        START: if (bit_end) begin
          cnt     <= '0;
          bcnt    <= '0;
          midi_tx <= sr[0];
          state   <= DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (bit_end) begin
          cnt <= '0;
          if (bcnt == 3'd7) begin
            bcnt    <= '0;
            midi_tx <= 1'b1;
            state   <= STOP;
          end else begin
            bcnt    <= bcnt + 1'b1;
            midi_tx <= sr[1];
            sr      <= {1'b1, sr[7:1]};
          end
        end else cnt <= cnt + 1'b1;
        STOP: begin
          // Registered pulse: set one cycle early so it lands on the last stop cycle.
          if (bcnt == S_LAST && cnt == C_PRE) frame_done <= 1'b1;
          if (bit_end) begin
            cnt <= '0;
            if (bcnt == S_LAST) begin
              bcnt <= '0;
              if (GAP_BITS > 0) begin
                gcnt  <= '0;
                state <= GAP;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else bcnt <= bcnt + 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        GAP: if (bit_end) begin
          cnt <= '0;
          if (gcnt == G_LAST) begin
            gcnt  <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else gcnt <= gcnt + 1'b1;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
